// File: rtl/de0qsys_pio_pkg.sv
// Shared constants for the de0qsys edge-capturing input PIO: register
// addresses, edge-type selectors and small parameter helpers.
package de0qsys_pio_pkg;

   localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
   localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
   localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   // A debounce length of zero behaves exactly like one.
   function automatic int deb_len(input int cycles);
      return (cycles < 1) ? 1 : cycles;
   endfunction

   function automatic int deb_cnt_width(input int cycles);
      return ($clog2(cycles + 1) < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/de0qsys_pio_in_bit.sv
// One input bit: synchroniser, debounce counter, debounced value and its
// one-cycle-delayed copy, plus the selected edge pulse.
module de0qsys_pio_in_bit
   import de0qsys_pio_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0,
   parameter int EDGE_TYPE       = 0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_bit,
   output logic deb,
   output logic edge_pulse
);

   localparam int D  = deb_len(DEBOUNCE_CYCLES);
   localparam int CW = deb_cnt_width(DEBOUNCE_CYCLES);

   logic [SYNC_STAGES-1:0] sync_r;
   logic [CW-1:0]          cnt_r;
   logic [CW-1:0]          cnt_nxt_s;
   logic                   deb_r;
   logic                   deb_nxt_s;
   logic                   deb_d_r;
   logic                   sync_s;

   assign sync_s = sync_r[SYNC_STAGES-1];

   // Synchroniser chain, debounce state and delayed debounced value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_r  <= '0;
         cnt_r   <= '0;
         deb_r   <= 1'b0;
         deb_d_r <= 1'b0;
      end else begin
         sync_r  <= {sync_r[SYNC_STAGES-2:0], in_bit};
         cnt_r   <= cnt_nxt_s;
         deb_r   <= deb_nxt_s;
         deb_d_r <= deb_r;
      end
   end

   // Count disagreeing cycles; flip the debounced value after D of them in a row.
   always_comb begin
      cnt_nxt_s = '0;
      deb_nxt_s = deb_r;
      if (sync_s != deb_r) begin
         if (cnt_r == CW'(D - 1)) begin
            deb_nxt_s = ~deb_r;
            cnt_nxt_s = '0;
         end else begin
            cnt_nxt_s = cnt_r + CW'(1'b1);
         end
      end else begin
         cnt_nxt_s = '0;
      end
   end

   // Edge pulse of the configured polarity.
   always_comb begin
      case (EDGE_TYPE)
         EDGE_RISE: edge_pulse = deb_r & ~deb_d_r;
         EDGE_FALL: edge_pulse = ~deb_r & deb_d_r;
         EDGE_ANY:  edge_pulse = deb_r ^ deb_d_r;
         default:   edge_pulse = deb_r & ~deb_d_r;
      endcase
   end

   assign deb = deb_r;

endmodule

// File: rtl/de0qsys_pio_in_edge.sv
// Avalon-MM input PIO with per-bit synchronise/debounce, sticky edge capture,
// interrupt mask and a registered level interrupt.
module de0qsys_pio_in_edge
   import de0qsys_pio_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0,
   parameter int EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int D      = deb_len(DEBOUNCE_CYCLES);
   localparam int SETTLE = SYNC_STAGES + D + 2;
   localparam int SW     = $clog2(SETTLE + 1);

   logic [WIDTH-1:0] deb_s;
   logic [WIDTH-1:0] edge_s;
   logic [WIDTH-1:0] irqmask_r;
   logic [WIDTH-1:0] irqmask_nxt_s;
   logic [WIDTH-1:0] edgecap_r;
   logic [WIDTH-1:0] edgecap_nxt_s;
   logic [SW-1:0]    settle_r;
   logic             settled_s;
   logic             wr_s;
   logic [31:0]      rd_nxt_s;
   logic [31:0]      readdata_r;
   logic             irq_r;
   logic             unused_wdata_s;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      de0qsys_pio_in_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .EDGE_TYPE       (EDGE_TYPE)
      ) u_bit (
         .clk        (clk),
         .reset_n    (reset_n),
         .in_bit     (in_port[i]),
         .deb        (deb_s[i]),
         .edge_pulse (edge_s[i])
      );
   end

   assign settled_s      = (settle_r == SW'(SETTLE));
   assign wr_s           = chipselect & ~write_n;
   assign unused_wdata_s = ^writedata;

   // Settle window: edges are ignored until the freshly reset pipeline has caught up with the pins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         settle_r <= '0;
      end else if (!settled_s) begin
         settle_r <= settle_r + SW'(1'b1);
      end else begin
         settle_r <= settle_r;
      end
   end

   // Register writes; a captured edge overrides a same-cycle write-1 clear.
   always_comb begin
      irqmask_nxt_s = irqmask_r;
      edgecap_nxt_s = edgecap_r;
      if (wr_s && (address == PIO_ADDR_IRQMASK)) begin
         irqmask_nxt_s = writedata[WIDTH-1:0];
      end else begin
         irqmask_nxt_s = irqmask_r;
      end
      if (wr_s && (address == PIO_ADDR_EDGECAP)) begin
         edgecap_nxt_s = edgecap_r & ~writedata[WIDTH-1:0];
      end else begin
         edgecap_nxt_s = edgecap_r;
      end
      if (settled_s) begin
         edgecap_nxt_s = edgecap_nxt_s | edge_s;
      end else begin
         edgecap_nxt_s = edgecap_nxt_s;
      end
   end

   // Read mux, zero-extended to the bus width.
   always_comb begin
      rd_nxt_s = '0;
      case (address)
         PIO_ADDR_DATA:    rd_nxt_s[WIDTH-1:0] = deb_s;
         PIO_ADDR_RSVD:    rd_nxt_s = '0;
         PIO_ADDR_IRQMASK: rd_nxt_s[WIDTH-1:0] = irqmask_r;
         PIO_ADDR_EDGECAP: rd_nxt_s[WIDTH-1:0] = edgecap_r;
         default:          rd_nxt_s = '0;
      endcase
   end

   // Control registers and registered bus outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqmask_r  <= '0;
         edgecap_r  <= '0;
         readdata_r <= '0;
         irq_r      <= 1'b0;
      end else begin
         irqmask_r  <= irqmask_nxt_s;
         edgecap_r  <= edgecap_nxt_s;
         readdata_r <= rd_nxt_s;
         irq_r      <= |(edgecap_r & irqmask_r);
      end
   end

   assign readdata = readdata_r;
   assign irq      = irq_r;

endmodule

// File: tb/tb_de0qsys_pio_in_edge.sv
// Bench for de0qsys_pio_in_edge: a rising-edge and an any-edge instance share
// stimulus; a cycle model and literal expectations check both.
module tb_de0qsys_pio_in_edge;

   localparam int S = 2;
   localparam int D = 3;
   localparam int N = S + D + 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] rd_rise, rd_any;
   logic        irq_rise, irq_any;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   de0qsys_pio_in_edge #(.WIDTH(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) dut_rise (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd_rise),
      .in_port(in_port), .irq(irq_rise));

   de0qsys_pio_in_edge #(.WIDTH(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut_any (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd_any),
      .in_port(in_port), .irq(irq_any));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Index 0 models the rising-edge instance, index 1 the any-edge instance.
   logic [3:0]  samples[$];
   logic [3:0]  m_deb, m_prev;
   int          run[4];
   logic [3:0]  m_mask;
   logic [3:0]  m_cap[2];
   logic        m_irq[2];
   logic [31:0] m_rd[2];
   int          k;

   task automatic m_reset();
      samples.delete();
      m_deb = 4'h0; m_prev = 4'h0; m_mask = 4'h0; k = 0;
      for (int b = 0; b < 4; b++) run[b] = 0;
      for (int i = 0; i < 2; i++) begin
         m_cap[i] = 4'h0; m_irq[i] = 1'b0; m_rd[i] = 32'h0;
      end
   endtask

   task automatic m_edge();
      logic [3:0] pins_seen, edges, clr;
      logic       wr;
      pins_seen = (samples.size() >= S) ? samples[samples.size() - S] : 4'h0;
      wr  = chipselect && !write_n;
      clr = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
      for (int i = 0; i < 2; i++) begin
         edges = (i == 0) ? (m_deb & ~m_prev) : (m_deb ^ m_prev);
         if (k < N) edges = 4'h0;
         m_irq[i] = |(m_cap[i] & m_mask);
         case (address)
            2'd0:    m_rd[i] = {28'h0, m_deb};
            2'd2:    m_rd[i] = {28'h0, m_mask};
            2'd3:    m_rd[i] = {28'h0, m_cap[i]};
            default: m_rd[i] = 32'h0;
         endcase
         m_cap[i] = (m_cap[i] & ~clr) | edges;
      end
      if (wr && address == 2'd2) m_mask = writedata[3:0];
      m_prev = m_deb;
      // A bit flips once the synchronised pin has disagreed for D cycles in a row.
      for (int b = 0; b < 4; b++) begin
         if (pins_seen[b] != m_deb[b]) begin
            run[b]++;
            if (run[b] == D) begin
               m_deb[b] = ~m_deb[b];
               run[b] = 0;
            end
         end else begin
            run[b] = 0;
         end
      end
      samples.push_back(in_port);
      if (samples.size() > S) void'(samples.pop_front());
      if (k < 1000) k++;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) m_reset();
         else m_edge();
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         check("model_rd_rise", rd_rise, m_rd[0]);
         check("model_rd_any", rd_any, m_rd[1]);
         check("model_irq_rise", {31'h0, irq_rise}, {31'h0, m_irq[0]});
         check("model_irq_any", {31'h0, irq_any}, {31'h0, m_irq[1]});
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      tick(1);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a);
      address = a;
      tick(1);
   endtask

   initial begin
      reset_n = 1'b0; in_port = 4'hF; address = 2'd0;
      chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
      tick(3);
      #1 check("reset_rd", rd_rise, 32'h0);
      check("reset_irq", {31'h0, irq_rise}, 32'h0);

      // 1: inputs high through reset settle without a capture
      reset_n = 1'b1;
      tick(12);
      check("t1_data", rd_rise, 32'h0000000F);
      bus_read(2'd3);
      check("t1_cap_rise", rd_rise, 32'h0);
      check("t1_cap_any", rd_any, 32'h0);
      check("t1_irq", {31'h0, irq_rise}, 32'h0);

      // falling edges are ignored by the rising instance only
      in_port = 4'h0;
      tick(10);
      check("fall_cap_rise", rd_rise, 32'h0);
      check("fall_cap_any", rd_any, 32'h0000000F);
      bus_write(2'd3, 32'h0000000F);
      bus_read(2'd3);
      check("clr_all_any", rd_any, 32'h0);
      bus_write(2'd2, 32'h00000001);

      // 3: a two-cycle glitch never reaches the debounced value
      in_port = 4'h2;
      tick(2);
      in_port = 4'h0;
      tick(10);
      bus_read(2'd0);
      check("t3_data", rd_rise, 32'h0);
      bus_read(2'd3);
      check("t3_cap", rd_rise, 32'h0);
      check("t3_irq", {31'h0, irq_rise}, 32'h0);

      // 2: debounce, capture and interrupt latency
      address = 2'd0;
      in_port = 4'h5;
      tick(5);
      check("t2_data_e5", rd_rise, 32'h0);
      tick(1);
      check("t2_data_e6", rd_rise, 32'h00000005);
      check("t2_irq_e6", {31'h0, irq_rise}, 32'h0);
      address = 2'd3;
      tick(1);
      check("t2_cap_e7", rd_rise, 32'h00000005);
      check("t2_irq_e7", {31'h0, irq_rise}, 32'h1);

      // 4: write-1-to-clear, and an edge beats a same-cycle clear
      bus_write(2'd3, 32'h00000001);
      tick(1);
      check("t4_clr_rise", rd_rise, 32'h00000004);
      check("t4_clr_any", rd_any, 32'h00000004);
      check("t4_irq_low", {31'h0, irq_rise}, 32'h0);
      in_port = 4'h4;
      tick(10);
      in_port = 4'h5;
      tick(5);
      bus_write(2'd3, 32'h00000001);
      tick(1);
      check("t4_edge_wins", rd_rise, 32'h00000005);
      bus_write(2'd3, 32'h00000001);
      tick(1);
      check("t4_reclear", rd_rise, 32'h00000004);

      // 5: any-edge mode captures both directions on bit 3; mask width
      bus_write(2'd3, 32'h0000000F);
      in_port = 4'hD;
      tick(8);
      bus_read(2'd3);
      check("t5_rise_any", rd_any, 32'h00000008);
      check("t5_rise_rise", rd_rise, 32'h00000008);
      bus_write(2'd3, 32'h0000000F);
      in_port = 4'h5;
      tick(8);
      bus_read(2'd3);
      check("t5_fall_any", rd_any, 32'h00000008);
      check("t5_fall_rise", rd_rise, 32'h0);
      bus_write(2'd2, 32'hFFFFFFFF);
      bus_read(2'd2);
      check("t5_mask", rd_rise, 32'h0000000F);

      // 6: reset mid-debounce clears at once, then the settle window hides the high pins
      bus_write(2'd3, 32'h0000000F);
      address = 2'd2;
      in_port = 4'hF;
      tick(4);
      reset_n = 1'b0;
      #1;
      check("t6_rd_now", rd_rise, 32'h0);
      check("t6_rd_any_now", rd_any, 32'h0);
      check("t6_irq_now", {31'h0, irq_any}, 32'h0);
      tick(2);
      reset_n = 1'b1;
      address = 2'd3;
      for (int c = 0; c < 12; c++) begin
         tick(1);
         check("t6_nocap_rise", rd_rise, 32'h0);
         check("t6_nocap_any", rd_any, 32'h0);
      end
      bus_read(2'd0);
      check("t6_data", rd_rise, 32'h0000000F);

      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
